if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage decoder/controller.
- Holds the PC and the IF/ID pipeline register.
- Selects next PC from sequential, jump (j/jal), register-jump (jr/jalr) or taken-branch redirects.
- Applies stall and flush so the decoder only sees valid instructions or NOP bubbles.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/if_stage_if.sv | 25 ++
 rtl/if_stage_pc_next_sel.sv | 66 ++++++
 rtl/if_stage.sv | 78 +++++++
 tb/tb_if_stage.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and types
// Jump selects, NOP encoding, opcode/func fields and the fetch next-PC selector.
package mips_pkg;

   localparam logic [1:0]  JMP_NONE  = 2'b00;
   localparam logic [1:0]  JMP_IMM   = 2'b01;
   localparam logic [1:0]  JMP_REG   = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0]  OP_RTYPE  = 6'h00;
   localparam logic [5:0]  OP_J      = 6'h02;
   localparam logic [5:0]  OP_JAL    = 6'h03;
   localparam logic [5:0]  OP_BEQ    = 6'h04;
   localparam logic [5:0]  OP_BNE    = 6'h05;
   localparam logic [5:0]  OP_ADDI   = 6'h08;
   localparam logic [5:0]  OP_LW     = 6'h23;
   localparam logic [5:0]  OP_SW     = 6'h2B;

   localparam logic [5:0]  FUNC_SLL  = 6'h00;
   localparam logic [5:0]  FUNC_JR   = 6'h08;
   localparam logic [5:0]  FUNC_JALR = 6'h09;
   localparam logic [5:0]  FUNC_ADD  = 6'h20;
   localparam logic [5:0]  FUNC_SUB  = 6'h22;
   localparam logic [5:0]  FUNC_AND  = 6'h24;
   localparam logic [5:0]  FUNC_OR   = 6'h25;
   localparam logic [5:0]  FUNC_SLT  = 6'h2A;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_HOLD,
      SEL_JMP,
      SEL_JR,
      SEL_BR
   } pc_sel_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: hazard/redirect inputs, imem port, IF/ID outputs
interface if_stage_if;
   logic        stall;
   logic [1:0]  jmp;
   logic [25:0] jmp_index;
   logic [31:0] jr_addr;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        redirect;

   modport master (
      input  stall, jmp, jmp_index, jr_addr, branch_taken, branch_target, imem_instr,
      output imem_addr, if_id_instr, if_id_pc4, if_id_valid, redirect
   );

   modport slave (
      output stall, jmp, jmp_index, jr_addr, branch_taken, branch_target, imem_instr,
      input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, redirect
   );
endinterface

// File: rtl/if_stage_pc_next_sel.sv
// rtl/if_stage_pc_next_sel.sv - combinational next-PC priority mux
// Priority: EX branch > stall > j/jal > jr/jalr > sequential.
module pc_next_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   input  logic        stall_i,
   input  logic [1:0]  jmp_i,
   input  logic [25:0] jmp_index_i,
   input  logic [31:0] jr_addr_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic [3:0]  pc4_hi_i,
   input  logic        if_id_valid_i,
   output logic [31:0] next_pc_o,
   output logic        bubble_sel_o,
   output logic        load_sel_o,
   output logic        redirect_o
);

   pc_sel_e sel;

   // A bubble in ID carries no real jump, so jmp only counts with a valid instruction.
   always_comb begin
      sel = SEL_SEQ;
      if (branch_taken_i)
         sel = SEL_BR;
      else if (stall_i)
         sel = SEL_HOLD;
      else if (if_id_valid_i && (jmp_i == JMP_IMM))
         sel = SEL_JMP;
      else if (if_id_valid_i && (jmp_i == JMP_REG))
         sel = SEL_JR;
   end

   always_comb begin
      next_pc_o    = pc_plus4_i;
      bubble_sel_o = 1'b0;
      load_sel_o   = 1'b0;
      case (sel)
         SEL_BR: begin
            next_pc_o    = word_align(branch_target_i);
            bubble_sel_o = 1'b1;
         end
         SEL_HOLD: begin
            next_pc_o    = pc_i;
         end
         SEL_JMP: begin
            next_pc_o    = {pc4_hi_i, jmp_index_i, 2'b00};
            bubble_sel_o = 1'b1;
         end
         SEL_JR: begin
            next_pc_o    = word_align(jr_addr_i);
            bubble_sel_o = 1'b1;
         end
         default: begin
            next_pc_o    = pc_plus4_i;
            load_sel_o   = 1'b1;
         end
      endcase
   end

   assign redirect_o = (sel == SEL_BR) || (sel == SEL_JMP) || (sel == SEL_JR);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register and IF/ID pipeline register
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.master  bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        bubble_sel;
   logic        load_sel;
   logic        redirect;

   assign pc_plus4 = pc_q + 32'd4;

   pc_next_sel u_pc_next_sel (
      .pc_i            (pc_q),
      .pc_plus4_i      (pc_plus4),
      .stall_i         (bus.stall),
      .jmp_i           (bus.jmp),
      .jmp_index_i     (bus.jmp_index),
      .jr_addr_i       (bus.jr_addr),
      .branch_taken_i  (bus.branch_taken),
      .branch_target_i (bus.branch_target),
      .pc4_hi_i        (pc4_q[31:28]),
      .if_id_valid_i   (valid_q),
      .next_pc_o       (next_pc),
      .bubble_sel_o    (bubble_sel),
      .load_sel_o      (load_sel),
      .redirect_o      (redirect)
   );

   // Neither bubble nor load means stall: IF/ID keeps its current contents.
   always_comb begin
      pc_d    = next_pc;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (bubble_sel) begin
         instr_d = NOP_INSTR;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end else if (load_sel) begin
         instr_d = bus.imem_instr;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc4   = pc4_q;
   assign bus.if_id_valid = valid_q;
   assign bus.redirect    = redirect;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   if_stage_if bus ();

   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory image: fixed word at 0, address-tagged words elsewhere.
   always_comb begin
      if (bus.imem_addr == 32'd0)
         bus.imem_instr = 32'h2008_0005;
      else
         bus.imem_instr = 32'hAB00_0000 ^ bus.imem_addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
      chk({tag, ".pc"},    bus.imem_addr,           pc);
      chk({tag, ".instr"}, bus.if_id_instr,         instr);
      chk({tag, ".pc4"},   bus.if_id_pc4,           pc4);
      chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
   endtask

   task automatic idle_inputs();
      bus.stall         = 1'b0;
      bus.jmp           = 2'b00;
      bus.jmp_index     = 26'd0;
      bus.jr_addr       = 32'd0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'd0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      idle_inputs();
      step();
      step();
      chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("reset.redirect", {31'd0, bus.redirect}, 32'd0);

      // Release and sequential fetch
      rst = 1'b1;
      #1;
      chk("rel.addr0", bus.imem_addr, 32'h0);
      step();
      chk_ifid("fetch1", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
      step();
      chk_ifid("fetch2", 32'h8, 32'hAB00_0004, 32'h8, 1'b1);
      step();
      chk_ifid("fetch3", 32'hC, 32'hAB00_0008, 32'hC, 1'b1);

      // Force PC to the top of memory through a branch, then wrap
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'hFFFF_FFFF;
      #1;
      chk("br_top.redirect", {31'd0, bus.redirect}, 32'd1);
      step();
      chk_ifid("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      idle_inputs();
      step();
      chk_ifid("wrap", 32'h0, 32'h54FF_FFFC, 32'h0, 1'b1);
      step();
      chk_ifid("after_wrap", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

      // j/jal: set if_id_pc4 = 1000_0010 first
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h1000_000C;
      step();
      idle_inputs();
      step();
      chk_ifid("pre_j", 32'h1000_0010, 32'hBB00_000C, 32'h1000_0010, 1'b1);
      bus.jmp       = 2'b01;
      bus.jmp_index = 26'h000_0040;
      #1;
      chk("j.redirect", {31'd0, bus.redirect}, 32'd1);
      step();
      chk_ifid("j", 32'h1000_0100, 32'h0, 32'h0, 1'b0);
      chk("j.bubble_redirect", {31'd0, bus.redirect}, 32'd0);
      step();
      chk("j.bubble_seq", bus.imem_addr, 32'h1000_0104);
      idle_inputs();

      // jr held by a 2-cycle stall
      bus.jmp     = 2'b10;
      bus.jr_addr = 32'h0000_0203;
      bus.stall   = 1'b1;
      #1;
      chk("jr_stall.redirect", {31'd0, bus.redirect}, 32'd0);
      step();
      chk_ifid("jr_stall1", 32'h1000_0104, 32'hBB00_0100, 32'h1000_0104, 1'b1);
      step();
      chk_ifid("jr_stall2", 32'h1000_0104, 32'hBB00_0100, 32'h1000_0104, 1'b1);
      bus.stall = 1'b0;
      #1;
      chk("jr.redirect", {31'd0, bus.redirect}, 32'd1);
      step();
      chk_ifid("jr", 32'h0000_0200, 32'h0, 32'h0, 1'b0);
      idle_inputs();
      step();
      chk_ifid("post_jr", 32'h0000_0204, 32'hAB00_0200, 32'h0000_0204, 1'b1);

      // Branch overrides coincident stall and jump
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_0080;
      bus.stall         = 1'b1;
      bus.jmp           = 2'b01;
      bus.jmp_index     = 26'h3FF_FFFF;
      #1;
      chk("br_prio.redirect", {31'd0, bus.redirect}, 32'd1);
      step();
      chk_ifid("br_prio", 32'h0000_0080, 32'h0, 32'h0, 1'b0);
      idle_inputs();

      // Back-to-back taken branches: latest target wins
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_0300;
      step();
      chk("b2b.first", bus.imem_addr, 32'h0000_0300);
      bus.branch_target = 32'h0000_0404;
      step();
      chk_ifid("b2b.second", 32'h0000_0404, 32'h0, 32'h0, 1'b0);
      idle_inputs();
      step();
      chk_ifid("b2b.resume", 32'h0000_0408, 32'hAB00_0404, 32'h0000_0408, 1'b1);

      // Asynchronous reset mid-stream
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h0000_003C;
      step();
      idle_inputs();
      step();
      chk_ifid("pre_rst", 32'h0000_0040, 32'hAB00_003C, 32'h0000_0040, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      step();
      rst = 1'b1;
      step();
      chk_ifid("rst_refetch", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
